// File: rtl/mux4_arb_pkg.sv
// Shared types and widths for the 4-input round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage : mux4_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of (req & ~excl) searching upward mod NUM_REQ from start.
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    input  logic [NUM_REQ-1:0] excl,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   pos;

    // Scan farthest-first so the closest candidate to start is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        cand  = req & ~excl;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = start + SEL_W'(k);
            if (cand[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux, with a per-owner hold quantum.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned QUANTUM = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] excl_c;
    logic [SEL_W-1:0]   win_c;
    logic               found_c;
    logic               quota_hit_c;

    // While owning, the current owner is removed from the search so it is lowest priority.
    assign excl_c = (state_q == ST_OWNED) ? (NUM_REQ'(1) << ptr_q) : '0;

    rr_pick u_pick (
        .req   (req),
        .start (ptr_q + SEL_W'(1)),
        .excl  (excl_c),
        .idx   (win_c),
        .found (found_c)
    );

    // This edge would bring the owner's tenure to QUANTUM cycles (or it is already saturated).
    assign quota_hit_c = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= (CNT_W + 1)'(QUANTUM);

    // Next-state, pointer, hold counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d = ST_OWNED;
                    ptr_d   = win_c;
                    cnt_d   = '0;
                    gnt_d   = NUM_REQ'(1) << win_c;
                    sel_d   = win_c;
                    busy_d  = 1'b1;
                end
            end
            ST_OWNED: begin
                if (!req[ptr_q] || (quota_hit_c && found_c)) begin
                    if (found_c) begin
                        ptr_d  = win_c;
                        cnt_d  = '0;
                        gnt_d  = NUM_REQ'(1) << win_c;
                        sel_d  = win_c;
                        busy_d = 1'b1;
                    end else begin
                        // Owner released and nobody else waiting; sel keeps its last value.
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (cnt_q < CNT_W'(QUANTUM)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; ptr resets to 3 so req[0] wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule : mux4_rr_arbiter

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter against a tenure-based round-robin model.
module tb_mux4_rr_arbiter;

    localparam int unsigned Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] din = 4'b0000;
    logic       y;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Model: current owner (-1 none), last owner, cycles the owner has held the grant, last select.
    int m_owner = -1;
    int m_last  = 3;
    int m_ten   = 0;
    int m_sel   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.QUANTUM(Q)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    // The 4:1 data mux steered by the arbiter.
    assign y = din[sel];

    function automatic int pick(input logic [3:0] r, input int from, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rs);
        int w;
        if (rs) begin
            m_owner = -1; m_last = 3; m_ten = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            w = pick(r, m_last, -1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_ten = 1; m_sel = w;
            end
        end else begin
            w = pick(r, m_owner, m_owner);
            if (!r[m_owner] || (m_ten >= int'(Q) && w >= 0)) begin
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_ten = 1; m_sel = w;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_ten++;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        din = 4'($urandom);
        @(posedge clk);
        model_step(r, rs);
        mon_en = 1'b1;
        #1;
    endtask

    // Continuous properties: one-hot grant, busy tracks grant, mux output follows the owner's data.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (!$onehot0(gnt)) begin
                bad++;
                $display("FAIL onehot: gnt=%b is not one-hot", gnt);
            end
            total++;
            if (busy !== (|gnt)) begin
                bad++;
                $display("FAIL busy: got %b want %b (gnt=%b)", busy, |gnt, gnt);
            end
            if (m_owner >= 0) begin
                total++;
                if (y !== din[m_owner]) begin
                    bad++;
                    $display("FAIL mux_y: got %b want %b (owner=%0d din=%b)", y, din[m_owner], m_owner, din);
                end
            end
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(4'b1111, 1'b1);
            total++;
            if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: gnt=%b sel=%b busy=%b want 0000/00/0", gnt, sel, busy);
            end
        end
        step(4'b1111, 1'b0);
        total++;
        if (gnt !== 4'b0001 || sel !== 2'b00) begin
            bad++;
            $display("FAIL reset_release: gnt=%b sel=%b want 0001/00", gnt, sel);
        end
    endtask

    task automatic test_single();
        step(4'b0000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(4'b0100, 1'b0);
            total++;
            if (gnt !== 4'b0100 || sel !== 2'b10) begin
                bad++;
                $display("FAIL single c%0d: gnt=%b sel=%b want 0100/10", c, gnt, sel);
            end
        end
        step(4'b0000, 1'b0);
        total++;
        if (gnt !== 4'b0000 || sel !== 2'b10) begin
            bad++;
            $display("FAIL single_release: gnt=%b sel=%b want 0000/10", gnt, sel);
        end
    endtask

    task automatic test_quantum();
        logic [3:0] want;
        step(4'b0000, 1'b1);
        for (int c = 0; c < 3 * int'(Q); c++) begin
            step(4'b0011, 1'b0);
            want = ((c / int'(Q)) % 2 == 0) ? 4'b0001 : 4'b0010;
            total++;
            if (gnt !== want || gnt !== exp_gnt() || sel !== 2'(m_sel)) begin
                bad++;
                $display("FAIL quantum c%0d: gnt=%b sel=%b want %b/%0d", c, gnt, sel, want, m_sel);
            end
        end
    endtask

    task automatic test_early_release();
        step(4'b0000, 1'b1);
        for (int c = 0; c < 3; c++) step(4'b1001, 1'b0);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL early_owner0: gnt=%b want 0001", gnt);
        end
        step(4'b1000, 1'b0);
        total++;
        if (gnt !== 4'b1000 || sel !== 2'b11) begin
            bad++;
            $display("FAIL early_switch: gnt=%b sel=%b want 1000/11", gnt, sel);
        end
        step(4'b0001, 1'b0);
        total++;
        if (gnt !== 4'b0001 || sel !== 2'b00) begin
            bad++;
            $display("FAIL early_wrap: gnt=%b sel=%b want 0001/00", gnt, sel);
        end
    endtask

    task automatic test_mid_reset();
        step(4'b0000, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0010, 1'b0);
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL midrst_own: gnt=%b want 0010", gnt);
        end
        step(4'b0010, 1'b1);
        total++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear: gnt=%b sel=%b busy=%b want 0000/00/0", gnt, sel, busy);
        end
        step(4'b0010, 1'b0);
        total++;
        if (gnt !== 4'b0010 || sel !== 2'b01) begin
            bad++;
            $display("FAIL midrst_regrant: gnt=%b sel=%b want 0010/01", gnt, sel);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rs;
        r = 4'b0000;
        step(4'b0000, 1'b1);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) r = 4'($urandom);
            rs = ($urandom_range(0, 59) == 0);
            step(r, rs);
            total++;
            if (gnt !== exp_gnt() || sel !== 2'(m_sel)) begin
                bad++;
                $display("FAIL random c%0d: req=%b gnt=%b sel=%b want %b/%0d", c, r, gnt, sel, exp_gnt(), m_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_quantum();
        test_early_release();
        test_mid_reset();
        test_random();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux4_rr_arbiter
